transpose_feed_ctrl: RTL and testbench

//  Sequencer for a bank of DIM transpose FIFOs feeding the systolic array.
//  - Load phase: accepts DIM matrix rows over a valid/ready handshake and fires a one-hot write strobe per FIFO (row i -> FIFO i).
//  - Drain phase: issues per-lane shift enables in a diagonal (skewed) schedule, so the array sees wavefront-aligned operands.
//  - Controls only: row data goes straight from the source to the FIFO Ain ports.

---
 rtl/transpose_feed_ctrl_pkg.sv | 26 ++
 rtl/transpose_feed_ctrl_if.sv | 41 ++++
 rtl/transpose_feed_ctrl_skew_window_gen.sv | 26 ++
 rtl/transpose_feed_ctrl.sv | 98 +++++++++
 tb/tb_transpose_feed_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/transpose_feed_ctrl_pkg.sv
// Shared state type and drain terminal count for the transpose feed sequencer.
// FEED_SKEW_EN selects diagonal drain windows; undefined gives lockstep lanes.
package transpose_feed_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } feed_state_t;

`ifdef FEED_SKEW_EN
  localparam bit FEED_SKEW = 1'b1;
`else
  localparam bit FEED_SKEW = 1'b0;
`endif

  function automatic int drain_last(
    input int dim,
    input int depth,
    input bit skew
  );
    return skew ? dim + depth - 2 : depth - 1;
  endfunction

endpackage

// File: rtl/transpose_feed_ctrl_if.sv
// Row handshake, FIFO strobes and job status bundle.
// master = row source / array side, slave = sequencer.
interface transpose_feed_ctrl_if #(
  parameter int DIM = 8
);

  logic           start;
  logic           row_valid;
  logic           row_ready;
  logic           stall;
  logic           busy;
  logic           done;
  logic [DIM-1:0] fifo_wren;
  logic [DIM-1:0] fifo_en;
  logic [DIM-1:0] lane_valid;

  modport master (
    output start,
    output row_valid,
    output stall,
    input  row_ready,
    input  fifo_wren,
    input  fifo_en,
    input  lane_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  row_valid,
    input  stall,
    output row_ready,
    output fifo_wren,
    output fifo_en,
    output lane_valid,
    output busy,
    output done
  );

endinterface

// File: rtl/transpose_feed_ctrl_skew_window_gen.sv
// Maps the drain cycle count to the set of lanes inside their window.
// FEED_SKEW_EN: lane i live for cyc in [i, i+DEPTH-1]; else all in [0, DEPTH-1].
module skew_window_gen #(
  parameter int DIM   = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic [CNT_W-1:0] cyc,
  output logic [DIM-1:0]   lane_in_win
);

  int c;

  always_comb begin
    lane_in_win = '0;
    c = int'(cyc);
    for (int i = 0; i < DIM; i++) begin
`ifdef FEED_SKEW_EN
      lane_in_win[i] = (c >= i) && (c <= i + DEPTH - 1);
`else
      lane_in_win[i] = (c <= DEPTH - 1);
`endif
    end
  end

endmodule

// File: rtl/transpose_feed_ctrl.sv
// Load/drain sequencer for a bank of DIM transpose FIFOs.
// FEED_SKEW_EN chooses skewed drain windows (see skew_window_gen).
module transpose_feed_ctrl
  import transpose_feed_pkg::*;
#(
  parameter int DIM   = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DIM + DEPTH)
) (
  input logic                 clk,
  input logic                 rst,
  transpose_feed_ctrl_if.slave bus
);

  localparam int RIW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(drain_last(DIM, DEPTH, FEED_SKEW));
  localparam logic [RIW-1:0] ROW_LAST = RIW'(DIM - 1);

  feed_state_t      state;
  feed_state_t      state_d;
  logic [RIW-1:0]   row_idx;
  logic [RIW-1:0]   row_idx_d;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] cyc_d;
  logic [DIM-1:0]   in_win;

  skew_window_gen #(
    .DIM   (DIM),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_win (
    .cyc         (cyc),
    .lane_in_win (in_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row_idx <= '0;
      cyc     <= '0;
    end else begin
      state   <= state_d;
      row_idx <= row_idx_d;
      cyc     <= cyc_d;
    end
  end

  always_comb begin
    state_d        = state;
    row_idx_d      = row_idx;
    cyc_d          = cyc;
    bus.row_ready  = 1'b0;
    bus.fifo_wren  = '0;
    bus.fifo_en    = '0;
    bus.lane_valid = '0;
    bus.busy       = (state != IDLE);
    bus.done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_d   = LOAD;
          row_idx_d = '0;
        end
      end
      LOAD: begin
        bus.row_ready = 1'b1;
        if (bus.row_valid) begin
          bus.fifo_wren[row_idx] = 1'b1;
          if (row_idx == ROW_LAST) begin
            state_d = DRAIN;
            cyc_d   = '0;
          end else begin
            row_idx_d = row_idx + 1'b1;
          end
        end
      end
      DRAIN: begin
        // stall freezes cyc, so lane_valid holds its current window
        bus.lane_valid = in_win;
        if (!bus.stall) begin
          bus.fifo_en = in_win;
          if (cyc == LAST) begin
            state_d = DONE;
          end else begin
            cyc_d = cyc + 1'b1;
          end
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_transpose_feed_ctrl.sv
// Bench for transpose_feed_ctrl: vector table, corner sequences, random vs model.
// Expectations follow FEED_SKEW_EN as compiled.
module tb_transpose_feed_ctrl;

  localparam int DIM   = 4;
  localparam int DEPTH = 4;
`ifdef FEED_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif
  localparam int L = SKEW ? DIM + DEPTH - 1 : DEPTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  transpose_feed_ctrl_if #(.DIM(DIM)) bus ();

  transpose_feed_ctrl #(
    .DIM   (DIM),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic       r, s, v, st;
    logic       rdy;
    logic [3:0] wren, en, lv;
    logic       bsy, dn;
  } vec_t;

  vec_t tbl[$];

  int total = 0;
  int bad   = 0;

  bit m_act;
  int m_rows;
  int m_k;

  logic [DIM-1:0] o_wr, o_en, o_lv;
  logic           o_rdy, o_bsy, o_dn;

  function automatic vec_t mk(
    input logic r, s, v, st, rdy,
    input logic [3:0] wren, en, lv,
    input logic bsy, dn
  );
    vec_t x;
    x.r = r; x.s = s; x.v = v; x.st = st;
    x.rdy = rdy; x.wren = wren; x.en = en; x.lv = lv;
    x.bsy = bsy; x.dn = dn;
    return x;
  endfunction

  function automatic logic [DIM-1:0] win(input int k);
    logic [DIM-1:0] w;
    w = '0;
    for (int i = 0; i < DIM; i++) begin
      if (SKEW ? (k >= i && k < i + DEPTH) : (k < DEPTH)) w[i] = 1'b1;
    end
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, s, v, st);
    logic loading, draining, finishing;
    logic [DIM-1:0] e_wren, e_en, e_lv;
    rst           = r;
    bus.start     = s;
    bus.row_valid = v;
    bus.stall     = st;
    @(negedge clk);
    loading   = m_act && (m_rows < DIM);
    draining  = m_act && (m_rows == DIM) && (m_k < L);
    finishing = m_act && (m_rows == DIM) && (m_k == L);
    e_wren = '0;
    if (loading && v) e_wren[m_rows] = 1'b1;
    e_lv = draining ? win(m_k) : '0;
    e_en = (draining && !st) ? win(m_k) : '0;
    chk("row_ready", bus.row_ready, loading);
    chk("fifo_wren", bus.fifo_wren, e_wren);
    chk("fifo_en", bus.fifo_en, e_en);
    chk("lane_valid", bus.lane_valid, e_lv);
    chk("busy", bus.busy, m_act);
    chk("done", bus.done, finishing);
    o_wr = bus.fifo_wren; o_en = bus.fifo_en; o_lv = bus.lane_valid;
    o_rdy = bus.row_ready; o_bsy = bus.busy; o_dn = bus.done;
    @(posedge clk);
    #1;
    if (r) begin
      m_act = 0; m_rows = 0; m_k = 0;
    end else if (!m_act) begin
      if (s) begin
        m_act = 1; m_rows = 0; m_k = 0;
      end
    end else if (loading) begin
      if (v) m_rows++;
    end else if (draining) begin
      if (!st) m_k++;
    end else begin
      m_act = 0;
    end
  endtask

  task automatic load_rows();
    step(0, 1, 0, 0);
    for (int i = 0; i < DIM; i++) step(0, 0, 1, 0);
  endtask

  initial begin
    int cnt;
    int lat;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.row_valid = 1'b0;
    bus.stall = 1'b0;
    m_act = 0; m_rows = 0; m_k = 0;
    @(posedge clk);
    #1;

    tbl.push_back(mk(1,1,1,0, 0,4'h0,4'h0,4'h0, 0,0));
    tbl.push_back(mk(0,0,1,0, 0,4'h0,4'h0,4'h0, 0,0));
    tbl.push_back(mk(0,1,1,0, 0,4'h0,4'h0,4'h0, 0,0));
    tbl.push_back(mk(0,0,1,0, 1,4'h1,4'h0,4'h0, 1,0));
    tbl.push_back(mk(0,0,1,0, 1,4'h2,4'h0,4'h0, 1,0));
    tbl.push_back(mk(0,0,1,0, 1,4'h4,4'h0,4'h0, 1,0));
    tbl.push_back(mk(0,0,1,0, 1,4'h8,4'h0,4'h0, 1,0));
`ifdef FEED_SKEW_EN
    tbl.push_back(mk(0,0,0,0, 0,4'h0,4'h1,4'h1, 1,0));
    tbl.push_back(mk(0,1,0,0, 0,4'h0,4'h3,4'h3, 1,0));
    tbl.push_back(mk(0,0,0,0, 0,4'h0,4'h7,4'h7, 1,0));
    tbl.push_back(mk(0,0,0,0, 0,4'h0,4'hf,4'hf, 1,0));
    tbl.push_back(mk(0,0,0,0, 0,4'h0,4'he,4'he, 1,0));
    tbl.push_back(mk(0,0,0,0, 0,4'h0,4'hc,4'hc, 1,0));
    tbl.push_back(mk(0,0,0,0, 0,4'h0,4'h8,4'h8, 1,0));
`else
    tbl.push_back(mk(0,0,0,0, 0,4'h0,4'hf,4'hf, 1,0));
    tbl.push_back(mk(0,1,0,0, 0,4'h0,4'hf,4'hf, 1,0));
    tbl.push_back(mk(0,0,0,0, 0,4'h0,4'hf,4'hf, 1,0));
    tbl.push_back(mk(0,0,0,0, 0,4'h0,4'hf,4'hf, 1,0));
`endif
    tbl.push_back(mk(0,1,0,0, 0,4'h0,4'h0,4'h0, 1,1));
    tbl.push_back(mk(0,0,0,0, 0,4'h0,4'h0,4'h0, 0,0));

    foreach (tbl[n]) begin
      step(tbl[n].r, tbl[n].s, tbl[n].v, tbl[n].st);
      chk("tbl_ready", o_rdy, tbl[n].rdy);
      chk("tbl_wren", o_wr, tbl[n].wren);
      chk("tbl_en", o_en, tbl[n].en);
      chk("tbl_lv", o_lv, tbl[n].lv);
      chk("tbl_busy", o_bsy, tbl[n].bsy);
      chk("tbl_done", o_dn, tbl[n].dn);
    end

    // source gaps: valid on every other cycle
    step(0, 1, 0, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, (i % 2 == 0), 0);
      if (o_wr != '0) cnt++;
    end
    chk("gap_strobes", cnt, 4);
    for (int i = 0; i < L + 2; i++) step(0, 0, 0, 0);

    load_rows();
    lat = 0;
    for (int d = 0; d < 30; d++) begin
      step(0, 0, 0, (d >= 2 && d < 5));
      if (d >= 2 && d < 5) begin
        chk("stall_lv", o_lv, win(2));
        chk("stall_en", o_en, 0);
      end
      if (o_dn && lat == 0) lat = d + 1;
    end
    chk("stall_done_lat", lat, L + 4);

    load_rows();
    for (int d = 0; d < 3; d++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("abort_lv", o_lv, 0);
    chk("abort_busy", o_bsy, 0);
    load_rows();
    cnt = 0;
    for (int d = 0; d < L + 2; d++) begin
      step(0, 0, 0, 0);
      if (o_dn) cnt++;
    end
    chk("clean_done", cnt, 1);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 64) == 0, ($urandom % 4) == 0,
           ($urandom % 2) == 0, ($urandom % 4) == 0);
      chk("disjoint", (o_wr != '0) && (o_en != '0), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
